// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial packed-BCD adder/subtractor.
// The sequencer and the digit slice both import this package.
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PASS1 = 2'd1,
      PASS2 = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic       OP_ADD   = 1'b0;
   localparam logic       OP_SUB   = 1'b1;
   localparam logic [3:0] BCD_MAX  = 4'd9;
   localparam logic [3:0] BCD_CORR = 4'd6;

endpackage

// File: rtl/bcd_digit_addsub.sv
// Single BCD digit add/subtract slice: s = a + (sub ? 9-b : b) + cin, decimal-corrected.
// It is purely combinational and is shared by both passes of the serial engine.
module bcd_digit_addsub
   import bcd_pkg::*;
(
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   input  logic       cin_i,
   input  logic       sub_i,
   output logic [3:0] s_o,
   output logic       cout_o,
   output logic       invalid_o
);

   logic [3:0] bEff;
   logic [4:0] dSum;

   // Adding 6 modulo 16 is the same as subtracting 10 for sums 10..19.
   always_comb begin
      bEff      = (sub_i == OP_SUB) ? (BCD_MAX - b_i) : b_i;
      dSum      = {1'b0, a_i} + {1'b0, bEff} + {4'b0000, cin_i};
      cout_o    = (dSum > {1'b0, BCD_MAX});
      s_o       = cout_o ? (dSum[3:0] + BCD_CORR) : dSum[3:0];
      invalid_o = (a_i > BCD_MAX) || (b_i > BCD_MAX);
   end

endmodule

// File: rtl/bcd_addsub_serial.sv
// Multi-digit packed-BCD add/subtract, one digit per clock LSD first, with sign-magnitude
// output. A negative difference is re-complemented by a second pass through the same slice.
module bcd_addsub_serial
   import bcd_pkg::*;
#(
   parameter int N_DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_op,
   input  logic [4*N_DIGITS-1:0] in_a,
   input  logic [4*N_DIGITS-1:0] in_b,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*N_DIGITS-1:0] out_result,
   output logic                  out_neg,
   output logic                  out_carry,
   output logic                  out_err
);

   localparam int W     = 4 * N_DIGITS;
   localparam int CNT_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_DIGITS - 1);

   state_t           state_q;
   logic [W-1:0]     aShift_q;
   logic [W-1:0]     bShift_q;
   logic [W-1:0]     res_q;
   logic [W-1:0]     res_d;
   logic             op_q;
   logic             carry_q;
   logic             err_q;
   logic             err_d;
   logic [CNT_W-1:0] cnt_q;
   logic [W-1:0]     outResult_q;
   logic             outValid_q;
   logic             outNeg_q;
   logic             outCarry_q;
   logic             outErr_q;

   logic [3:0] sliceA;
   logic [3:0] sliceB;
   logic       sliceSub;
   logic [3:0] sliceS;
   logic       sliceCout;
   logic       sliceInvalid;
   logic       lastDigit;

   bcd_digit_addsub u_slice (
      .a_i       (sliceA),
      .b_i       (sliceB),
      .cin_i     (carry_q),
      .sub_i     (sliceSub),
      .s_o       (sliceS),
      .cout_o    (sliceCout),
      .invalid_o (sliceInvalid)
   );

   // Pass 2 computes 0 - R digit by digit, rotating R through the same shift path.
   always_comb begin
      sliceA   = aShift_q[3:0];
      sliceB   = bShift_q[3:0];
      sliceSub = op_q;
      if (state_q == PASS2) begin
         sliceA   = 4'd0;
         sliceB   = res_q[3:0];
         sliceSub = OP_SUB;
      end
      res_d           = res_q >> 4;
      res_d[W-1 -: 4] = sliceS;
      err_d           = err_q | sliceInvalid;
      lastDigit       = (cnt_q == LAST_CNT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         aShift_q    <= '0;
         bShift_q    <= '0;
         res_q       <= '0;
         op_q        <= OP_ADD;
         carry_q     <= 1'b0;
         err_q       <= 1'b0;
         cnt_q       <= '0;
         outResult_q <= '0;
         outValid_q  <= 1'b0;
         outNeg_q    <= 1'b0;
         outCarry_q  <= 1'b0;
         outErr_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  aShift_q <= in_a;
                  bShift_q <= in_b;
                  op_q     <= in_op;
                  carry_q  <= in_op;
                  err_q    <= 1'b0;
                  cnt_q    <= '0;
                  state_q  <= PASS1;
               end
            end
            PASS1: begin
               aShift_q <= aShift_q >> 4;
               bShift_q <= bShift_q >> 4;
               res_q    <= res_d;
               carry_q  <= sliceCout;
               err_q    <= err_d;
               cnt_q    <= cnt_q + CNT_W'(1);
               if (lastDigit) begin
                  cnt_q <= '0;
                  if (err_d) begin
                     outResult_q <= '0;
                     outNeg_q    <= 1'b0;
                     outCarry_q  <= 1'b0;
                     outErr_q    <= 1'b1;
                     outValid_q  <= 1'b1;
                     state_q     <= DONE;
                  end else if (op_q == OP_ADD || sliceCout) begin
                     outResult_q <= res_d;
                     outNeg_q    <= 1'b0;
                     outCarry_q  <= (op_q == OP_ADD) ? sliceCout : 1'b0;
                     outErr_q    <= 1'b0;
                     outValid_q  <= 1'b1;
                     state_q     <= DONE;
                  end else begin
                     carry_q <= 1'b1;
                     state_q <= PASS2;
                  end
               end
            end
            PASS2: begin
               res_q   <= res_d;
               carry_q <= sliceCout;
               cnt_q   <= cnt_q + CNT_W'(1);
               if (lastDigit) begin
                  cnt_q       <= '0;
                  outResult_q <= res_d;
                  outNeg_q    <= 1'b1;
                  outCarry_q  <= 1'b0;
                  outErr_q    <= 1'b0;
                  outValid_q  <= 1'b1;
                  state_q     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  outValid_q <= 1'b0;
                  state_q    <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready   = (state_q == IDLE);
   assign out_valid  = outValid_q;
   assign out_result = outResult_q;
   assign out_neg    = outNeg_q;
   assign out_carry  = outCarry_q;
   assign out_err    = outErr_q;

endmodule

// File: tb/tb_bcd_addsub_serial.sv
// Directed self-checking bench for bcd_addsub_serial with four BCD digits.
module tb_bcd_addsub_serial;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic        in_op;
   logic [15:0] in_a;
   logic [15:0] in_b;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_result;
   logic        out_neg;
   logic        out_carry;
   logic        out_err;

   int total = 0;
   int bad   = 0;

   bcd_addsub_serial #(.N_DIGITS(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_a       (in_a),
      .in_b       (in_b),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_neg    (out_neg),
      .out_carry  (out_carry),
      .out_err    (out_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present one operation, let it be accepted, then count edges until out_valid (-1 on timeout).
   task automatic applyStimulus(input logic op, input logic [15:0] a, input logic [15:0] b,
                                output int edges);
      @(negedge clk);
      in_valid = 1'b1;
      in_op    = op;
      in_a     = a;
      in_b     = b;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      edges    = 0;
      while (!out_valid && edges < 64) begin
         @(posedge clk);
         #1;
         edges++;
      end
      if (!out_valid) edges = -1;
   endtask

   task automatic acceptResult();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready got=%b want=1", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid got=%b want=0", out_valid); end
      total++; if (out_result !== 16'h0000) begin bad++; $display("[TB] FAIL reset_result got=%h want=0000", out_result); end
      total++; if (out_neg !== 1'b0) begin bad++; $display("[TB] FAIL reset_neg got=%b want=0", out_neg); end
      total++; if (out_carry !== 1'b0) begin bad++; $display("[TB] FAIL reset_carry got=%b want=0", out_carry); end
      total++; if (out_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_err got=%b want=0", out_err); end
   endtask

   task automatic test_add();
      int edges;
      applyStimulus(1'b0, 16'h1234, 16'h5678, edges);
      total++; if (edges !== 4) begin bad++; $display("[TB] FAIL add1_latency got=%0d want=4", edges); end
      total++; if (out_result !== 16'h6912) begin bad++; $display("[TB] FAIL add1_result got=%h want=6912", out_result); end
      total++; if (out_carry !== 1'b0) begin bad++; $display("[TB] FAIL add1_carry got=%b want=0", out_carry); end
      total++; if (out_neg !== 1'b0) begin bad++; $display("[TB] FAIL add1_neg got=%b want=0", out_neg); end
      acceptResult();
      applyStimulus(1'b0, 16'h9999, 16'h0001, edges);
      total++; if (out_result !== 16'h0000) begin bad++; $display("[TB] FAIL add2_result got=%h want=0000", out_result); end
      total++; if (out_carry !== 1'b1) begin bad++; $display("[TB] FAIL add2_carry got=%b want=1", out_carry); end
      acceptResult();
      applyStimulus(1'b0, 16'h0000, 16'h0000, edges);
      total++; if (out_result !== 16'h0000) begin bad++; $display("[TB] FAIL add3_result got=%h want=0000", out_result); end
      total++; if (out_carry !== 1'b0) begin bad++; $display("[TB] FAIL add3_carry got=%b want=0", out_carry); end
      acceptResult();
      applyStimulus(1'b0, 16'h9999, 16'h9999, edges);
      total++; if (out_result !== 16'h9998) begin bad++; $display("[TB] FAIL add4_result got=%h want=9998", out_result); end
      total++; if (out_carry !== 1'b1) begin bad++; $display("[TB] FAIL add4_carry got=%b want=1", out_carry); end
      acceptResult();
   endtask

   task automatic test_sub();
      int edges;
      applyStimulus(1'b1, 16'h0500, 16'h0123, edges);
      total++; if (edges !== 4) begin bad++; $display("[TB] FAIL sub1_latency got=%0d want=4", edges); end
      total++; if (out_result !== 16'h0377) begin bad++; $display("[TB] FAIL sub1_result got=%h want=0377", out_result); end
      total++; if (out_neg !== 1'b0) begin bad++; $display("[TB] FAIL sub1_neg got=%b want=0", out_neg); end
      acceptResult();
      applyStimulus(1'b1, 16'h0123, 16'h0500, edges);
      total++; if (edges !== 8) begin bad++; $display("[TB] FAIL sub2_latency got=%0d want=8", edges); end
      total++; if (out_result !== 16'h0377) begin bad++; $display("[TB] FAIL sub2_result got=%h want=0377", out_result); end
      total++; if (out_neg !== 1'b1) begin bad++; $display("[TB] FAIL sub2_neg got=%b want=1", out_neg); end
      total++; if (out_carry !== 1'b0) begin bad++; $display("[TB] FAIL sub2_carry got=%b want=0", out_carry); end
      acceptResult();
      applyStimulus(1'b1, 16'h4321, 16'h4321, edges);
      total++; if (out_result !== 16'h0000) begin bad++; $display("[TB] FAIL sub3_result got=%h want=0000", out_result); end
      total++; if (out_neg !== 1'b0) begin bad++; $display("[TB] FAIL sub3_neg got=%b want=0", out_neg); end
      acceptResult();
      applyStimulus(1'b1, 16'h0000, 16'h0000, edges);
      total++; if (out_result !== 16'h0000) begin bad++; $display("[TB] FAIL sub4_result got=%h want=0000", out_result); end
      total++; if (out_neg !== 1'b0) begin bad++; $display("[TB] FAIL sub4_neg got=%b want=0", out_neg); end
      acceptResult();
   endtask

   task automatic test_invalid_digit();
      int edges;
      applyStimulus(1'b0, 16'h12A4, 16'h0001, edges);
      total++; if (out_err !== 1'b1) begin bad++; $display("[TB] FAIL err1_flag got=%b want=1", out_err); end
      total++; if (out_result !== 16'h0000) begin bad++; $display("[TB] FAIL err1_result got=%h want=0000", out_result); end
      total++; if (out_carry !== 1'b0) begin bad++; $display("[TB] FAIL err1_carry got=%b want=0", out_carry); end
      acceptResult();
      applyStimulus(1'b0, 16'h0001, 16'h0001, edges);
      total++; if (out_err !== 1'b0) begin bad++; $display("[TB] FAIL err2_flag got=%b want=0", out_err); end
      total++; if (out_result !== 16'h0002) begin bad++; $display("[TB] FAIL err2_result got=%h want=0002", out_result); end
      acceptResult();
   endtask

   task automatic test_backpressure();
      int edges;
      applyStimulus(1'b0, 16'h0002, 16'h0003, edges);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_a     = 16'h1111;
         in_b     = 16'h2222;
         @(posedge clk);
         #1;
         total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_valid cyc=%0d got=%b want=1", i, out_valid); end
         total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_in_ready cyc=%0d got=%b want=0", i, in_ready); end
         total++; if (out_result !== 16'h0005) begin bad++; $display("[TB] FAIL bp_result cyc=%0d got=%h want=0005", i, out_result); end
      end
      @(negedge clk);
      in_valid = 1'b0;
      acceptResult();
      total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_release_valid got=%b want=0", out_valid); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL bp_release_in_ready got=%b want=1", in_ready); end
      total++; if (out_result !== 16'h0005) begin bad++; $display("[TB] FAIL bp_release_hold got=%h want=0005", out_result); end
      @(posedge clk);
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL bp_idle_stays got=%b want=1", in_ready); end
   endtask

   task automatic test_reset_abort();
      int edges;
      @(negedge clk);
      in_valid = 1'b1;
      in_op    = 1'b1;
      in_a     = 16'h0123;
      in_b     = 16'h0500;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL abort_in_ready got=%b want=1", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL abort_valid got=%b want=0", out_valid); end
      total++; if (out_result !== 16'h0000) begin bad++; $display("[TB] FAIL abort_result got=%h want=0000", out_result); end
      total++; if (out_neg !== 1'b0) begin bad++; $display("[TB] FAIL abort_neg got=%b want=0", out_neg); end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL abort_after_valid got=%b want=0", out_valid); end
      applyStimulus(1'b1, 16'h0007, 16'h0009, edges);
      total++; if (edges !== 8) begin bad++; $display("[TB] FAIL post_abort_latency got=%0d want=8", edges); end
      total++; if (out_result !== 16'h0002) begin bad++; $display("[TB] FAIL post_abort_result got=%h want=0002", out_result); end
      total++; if (out_neg !== 1'b1) begin bad++; $display("[TB] FAIL post_abort_neg got=%b want=1", out_neg); end
      acceptResult();
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_op     = 1'b0;
      in_a      = '0;
      in_b      = '0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      test_reset();
      test_add();
      test_sub();
      test_invalid_digit();
      test_backpressure();
      test_reset_abort();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
